// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared pipeline constants for operand forwarding
package cpu_pipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
    localparam int FWD_EXMEM  = 1;
    localparam int FWD_MEMWB  = 2;
endpackage

// File: rtl/fwd_prio_sel.sv
// rtl/fwd_prio_sel.sv - priority address match, operand select and load-use hazard detect
module fwd_prio_sel
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NSRC   = 3,
    parameter int SEL_W  = $clog2(NSRC)
) (
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        rs_addr,
    input  logic [DATA_W-1:0]        rf_data,
    input  logic [NSRC-2:0]          fwd_valid,
    input  logic [(NSRC-1)*ADDR_W-1:0] fwd_addr,
    input  logic [(NSRC-1)*DATA_W-1:0] fwd_data,
    input  logic [NSRC-2:0]          fwd_pending,
    output logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        data,
    output logic                     hazard
);
    logic not_zero;
    logic sel_pending;

    assign not_zero = (rs_addr != ADDR_W'(REG_ZERO));

    // Scan oldest to youngest so the youngest match is written last and wins.
    always_comb begin
        sel         = '0;
        data        = not_zero ? rf_data : '0;
        sel_pending = 1'b0;
        for (int k = NSRC - 1; k >= 1; k--) begin
            if (not_zero && fwd_valid[k-1] && (fwd_addr[k*ADDR_W-1 -: ADDR_W] == rs_addr)) begin
                sel         = SEL_W'(k);
                data        = fwd_data[k*DATA_W-1 -: DATA_W];
                sel_pending = fwd_pending[k-1];
            end
        end
    end

    assign hazard = in_valid && sel_pending;
endmodule

// File: rtl/operand_fwd_mux.sv
// rtl/operand_fwd_mux.sv - forwarding mux with one-entry registered output slot and stall counter
module operand_fwd_mux
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NSRC   = 3,
    parameter int SEL_W  = $clog2(NSRC),
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          rs_addr,
    input  logic [DATA_W-1:0]          rf_data,
    input  logic [NSRC-2:0]            fwd_valid,
    input  logic [(NSRC-1)*ADDR_W-1:0] fwd_addr,
    input  logic [(NSRC-1)*DATA_W-1:0] fwd_data,
    input  logic [NSRC-2:0]            fwd_pending,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [SEL_W-1:0]           out_sel,
    output logic [CNT_W-1:0]           stall_cnt
);
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] sel_data;
    logic              hazard;
    logic              accept;

    fwd_prio_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NSRC   (NSRC),
        .SEL_W  (SEL_W)
    ) u_sel (
        .in_valid    (in_valid),
        .rs_addr     (rs_addr),
        .rf_data     (rf_data),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .fwd_pending (fwd_pending),
        .sel         (sel),
        .data        (sel_data),
        .hazard      (hazard)
    );

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Flushed cycles are not stalls: the request is being killed anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
